// File: rtl/dilithium_adapter_pkg.sv
// Shared types and header-length table for the Dilithium host stream adapters.
package dilithium_adapter_pkg;

    localparam int unsigned HDR_CNT_W = 10;

    typedef enum logic [1:0] {
        MODE_KEYGEN = 2'd0,
        MODE_SIGN   = 2'd1,
        MODE_VERIFY = 2'd2
    } mode_e;

    localparam logic [2:0] SEC_LVL_2 = 3'd2;
    localparam logic [2:0] SEC_LVL_3 = 3'd3;
    localparam logic [2:0] SEC_LVL_5 = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_MESSAGE,
        ST_DRAIN,
        ST_FLUSH
    } state_e;

    // Header length in 64-bit words; 0 flags an illegal mode/level pair.
    function automatic logic [HDR_CNT_W-1:0] hdr_words(input logic [1:0] mode,
                                                       input logic [2:0] sec_lvl);
        logic [HDR_CNT_W-1:0] w;
        w = '0;
        if (mode == MODE_KEYGEN) begin
            case (sec_lvl)
                SEC_LVL_2, SEC_LVL_3, SEC_LVL_5: w = 10'd4;
                default:                         w = '0;
            endcase
        end else if (mode == MODE_SIGN) begin
            case (sec_lvl)
                SEC_LVL_2: w = 10'd320;
                SEC_LVL_3: w = 10'd504;
                SEC_LVL_5: w = 10'd612;
                default:   w = '0;
            endcase
        end else if (mode == MODE_VERIFY) begin
            case (sec_lvl)
                SEC_LVL_2: w = 10'd467;
                SEC_LVL_3: w = 10'd658;
                SEC_LVL_5: w = 10'd903;
                default:   w = '0;
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry valid/ready register slice; full throughput when the sink is ready.
module stream_reg_slice #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dilithium_input_adapter.sv
// Host ingress adapter: enforces per-mode header length and frames the final
// word toward combined_top through a one-entry output register.
module dilithium_input_adapter
    import dilithium_adapter_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [2:0]        sec_lvl,
    input  logic              valid_i,
    output logic              ready_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    output logic              core_valid_o,
    input  logic              core_ready_o,
    output logic [DATA_W-1:0] core_data_o,
    output logic              core_last_o,
    output logic              busy,
    output logic              done,
    output logic              err_cfg,
    output logic              err_early_last,
    output logic              err_missing_last
);

    state_e           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] hdr_q, hdr_n;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] cfg_hdr;
    logic             keygen_q, keygen_n;
    logic             busy_n, done_n;
    logic             err_cfg_n, err_early_n, err_missing_n;
    logic             slice_ready;
    logic             push, push_last;
    logic             host_xfer;
    logic             hdr_end;

    assign cfg_hdr   = CNT_W'(hdr_words(mode, sec_lvl));
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign hdr_end   = (cnt_inc == hdr_q);
    assign host_xfer = valid_i && ready_i;

    stream_reg_slice #(
        .DATA_W(DATA_W)
    ) u_out_slice (
        .clk      (clk),
        .rst_n    (rst),
        .in_valid (push),
        .in_ready (slice_ready),
        .in_data  (data_i),
        .in_last  (push_last),
        .out_valid(core_valid_o),
        .out_ready(core_ready_o),
        .out_data (core_data_o),
        .out_last (core_last_o)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            hdr_q            <= '0;
            keygen_q         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_cfg          <= 1'b0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
        end else begin
            state_q          <= state_n;
            cnt_q            <= cnt_n;
            hdr_q            <= hdr_n;
            keygen_q         <= keygen_n;
            busy             <= busy_n;
            done             <= done_n;
            err_cfg          <= err_cfg_n;
            err_early_last   <= err_early_n;
            err_missing_last <= err_missing_n;
        end
    end

    always_comb begin
        state_n       = state_q;
        cnt_n         = cnt_q;
        hdr_n         = hdr_q;
        keygen_n      = keygen_q;
        busy_n        = busy;
        done_n        = 1'b0;
        err_cfg_n     = err_cfg;
        err_early_n   = err_early_last;
        err_missing_n = err_missing_last;
        push          = 1'b0;
        push_last     = 1'b0;
        ready_i       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_cfg_n     = 1'b0;
                    err_early_n   = 1'b0;
                    err_missing_n = 1'b0;
                    if (cfg_hdr == '0) begin
                        err_cfg_n = 1'b1;
                    end else begin
                        hdr_n    = cfg_hdr;
                        keygen_n = (mode == MODE_KEYGEN);
                        cnt_n    = '0;
                        busy_n   = 1'b1;
                        state_n  = ST_HEADER;
                    end
                end
            end

            ST_HEADER: begin
                ready_i = slice_ready;
                if (host_xfer) begin
                    if (cnt_q < hdr_q) begin
                        cnt_n = cnt_inc;
                    end
                    if (!hdr_end && last_i) begin
                        // Truncated header: the offending word never reaches the core.
                        err_early_n = 1'b1;
                        busy_n      = 1'b0;
                        state_n     = ST_IDLE;
                    end else if (hdr_end) begin
                        push      = 1'b1;
                        push_last = keygen_q || last_i;
                        if (keygen_q && !last_i) begin
                            err_missing_n = 1'b1;
                            state_n       = ST_DRAIN;
                        end else if (last_i) begin
                            state_n = ST_FLUSH;
                        end else begin
                            state_n = ST_MESSAGE;
                        end
                    end else begin
                        push = 1'b1;
                    end
                end
            end

            ST_MESSAGE: begin
                ready_i = slice_ready;
                if (host_xfer) begin
                    push      = 1'b1;
                    push_last = last_i;
                    if (last_i) begin
                        state_n = ST_FLUSH;
                    end
                end
            end

            ST_DRAIN: begin
                ready_i = 1'b1;
                if (host_xfer && last_i) begin
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end
            end

            ST_FLUSH: begin
                if (core_valid_o && core_ready_o && core_last_o) begin
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end
            end

            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/dilithium_input_adapter.md
Name: dilithium_input_adapter

Overview:
- Host-side ingress adapter for the Dilithium accelerator.
- Accepts a framed 64-bit host stream (valid/ready/data/last) and forwards it to combined_top's input port.
- Enforces the per-mode, per-security-level header length and marks the final word toward the core.
- Sits between the host input interface and combined_top; it is the counterpart of the output-side adapter.

Parameters:
- DATA_W, 64, stream word width.
- CNT_W, 10, header word counter width (max header 903 words).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle start strobe (already edge-detected upstream).
- mode  in  2  0 keygen, 1 sign, 2 verify, 3 illegal.
- sec_lvl  in  3  2, 3 or 5; any other value is illegal.
- valid_i  in  1  host word valid.
- ready_i  out  1  adapter accepts host word.
- data_i  in  64  host word.
- last_i  in  1  host end-of-frame marker.
- core_valid_o  out  1  word valid toward core.
- core_ready_o  in  1  core accepts word.
- core_data_o  out  64  word toward core.
- core_last_o  out  1  final word of operation.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when the final word is accepted by the core.
- err_cfg  out  1  sticky: illegal mode/sec_lvl at start.
- err_early_last  out  1  sticky: last_i seen before header complete.
- err_missing_last  out  1  sticky: keygen word 4 without last_i.

Behaviour:
- Fixed decisions: one clock; reset is asynchronous and active-low.
- Reset: all outputs 0; state IDLE; counter 0.
- Header length HDR in words, byte counts rounded up to 64-bit words:
  - keygen: 4 for all levels.
  - sign (sk): 320 / 504 / 612 for levels 2 / 3 / 5.
  - verify (pk+sig): 467 / 658 / 903 for levels 2 / 3 / 5.
- Word handshake: a word transfers when valid_i && ready_i.
- Output register: one-entry output register (core_valid_o/data/last).
  - ready_i = accepting_state && (!core_valid_o || core_ready_o).
  - Latency data_i -> core_data_o is 1 cycle.
  - core_* is held stable while core_valid_o && !core_ready_o.
- State IDLE:
  - ready_i = 0.
  - On start, latch mode/sec_lvl and clear all err_* flags.
  - Illegal configuration: set err_cfg and stay in IDLE.
  - Otherwise load HDR, clear the counter, set busy, go to HEADER.
  - start in any other state is ignored.
- State HEADER: forward each transferred word and increment the counter.
  - last_i on word n < HDR: set err_early_last, drop the word (not forwarded), clear busy, go to IDLE.
  - Word n == HDR, keygen, last_i = 1: forward with core_last_o = 1, go to FLUSH.
  - Word n == HDR, keygen, last_i = 0: set err_missing_last, forward with core_last_o = 1, go to DRAIN.
  - Word n == HDR, sign/verify, last_i = 1 (empty message): forward with core_last_o = 1, go to FLUSH.
  - Word n == HDR, sign/verify, last_i = 0: forward, go to MESSAGE.
- State MESSAGE:
  - Forward every word.
  - Word with last_i: forward with core_last_o = 1, go to FLUSH.
  - There is no message length limit.
- State DRAIN:
  - ready_i = 1; words are discarded and not forwarded.
  - On last_i: clear busy, go to IDLE.
- State FLUSH:
  - ready_i = 0.
  - When the registered last word transfers to the core: pulse done, clear busy, go to IDLE.
- Simultaneous events: a core-side transfer and a host-side load in the same cycle are allowed (full throughput, 1 word/cycle).
- Counter: saturates at HDR and never wraps.

Decomposition:
- Package dilithium_adapter_pkg holds:
  - mode enum (MODE_KEYGEN/SIGN/VERIFY).
  - security level constants.
  - header-length function hdr_words(mode, sec_lvl) returning CNT_W bits, 0 for illegal input.
  - FSM state typedef.
- Sub-module stream_reg_slice: the one-entry valid/ready output register, reusable by the output adapter.

Test Plan:
- Keygen level 2 happy path:
  - Stimulus: start (mode 0, sec_lvl 2), 4 words 0x1..0x4 with last on word 4, core_ready_o = 1.
  - Required: core sees 0x1..0x4, core_last_o on 0x4, done pulse, no err_* flags.
- Sign level 3 with backpressure:
  - Stimulus: 504 header words plus 3 message words, last on the final word; core_ready_o toggled 1/0 every cycle.
  - Required: 507 words delivered in order, none lost or duplicated, data stable while stalled, core_last_o only on word 507.
- Verify level 5 early last:
  - Stimulus: last_i on word 100.
  - Required: err_early_last = 1, 99 words forwarded, word 100 dropped, return to IDLE, busy = 0.
- Keygen missing last:
  - Stimulus: 6 words, last on word 6.
  - Required: err_missing_last = 1, 4 words forwarded with core_last_o on word 4, words 5–6 drained, then IDLE.
- Illegal configuration:
  - Stimulus: start with sec_lvl 4, then start with mode 3.
  - Required: err_cfg = 1 each time, ready_i stays 0, busy = 0.
- Reset mid-operation:
  - Stimulus: assert rst low during MESSAGE of a verify level 2 operation with core_valid_o = 1.
  - Required: all outputs 0 immediately (asynchronous); a fresh start then completes normally.
